// File: rtl/sp_noise_injector.sv
// Salt-and-pepper noise injector for an 8-bit luma stream with a single
// output register stage, per-frame LFSR reseed and per-frame hit counters.
module sp_noise_injector #(
   parameter logic [7:0]  SALT_VAL   = 8'd255,
   parameter logic [7:0]  PEPPER_VAL = 8'd0,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1,
   parameter int unsigned CNT_W      = 20
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             noise_en,
   input  logic [8:0]       density,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_y,
   input  logic             in_sof,
   input  logic             in_eof,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_y,
   output logic             out_sof,
   output logic             out_eof,
   output logic [CNT_W-1:0] salt_cnt,
   output logic [CNT_W-1:0] pepper_cnt,
   output logic [CNT_W-1:0] frame_hits
);

   // An all-zero seed would lock the LFSR, so it is promoted to 1.
   localparam logic [15:0]      C_SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
   localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

   logic [15:0]      r_lfsr;
   logic             r_out_valid;
   logic [7:0]       r_out_y;
   logic             r_out_sof;
   logic             r_out_eof;
   logic [CNT_W-1:0] r_salt;
   logic [CNT_W-1:0] r_pepper;
   logic [CNT_W-1:0] r_frame_hits;

   logic             w_accept;
   logic [15:0]      w_l;
   logic [15:0]      w_l_next;
   logic [8:0]       w_dens;
   logic             w_hit;
   logic             w_salt_hit;
   logic             w_pepper_hit;
   logic [7:0]       w_y;
   logic [CNT_W-1:0] w_salt_base;
   logic [CNT_W-1:0] w_pepper_base;
   logic [CNT_W-1:0] w_salt_new;
   logic [CNT_W-1:0] w_pepper_new;
   logic [CNT_W:0]   w_sum;
   logic [CNT_W-1:0] w_sum_sat;

   assign in_ready = !r_out_valid || out_ready;
   assign w_accept = in_valid && in_ready;

   always_comb begin
      w_l      = in_sof ? C_SEED : r_lfsr;
      w_l_next = (w_l >> 1) ^ (w_l[0] ? 16'hB400 : 16'h0000);
      w_dens   = density[8] ? 9'd256 : density;
      w_hit    = noise_en && ({1'b0, w_l[7:0]} < w_dens);
      w_salt_hit   = w_hit && w_l[8];
      w_pepper_hit = w_hit && !w_l[8];
      if (w_salt_hit)
         w_y = SALT_VAL;
      else if (w_pepper_hit)
         w_y = PEPPER_VAL;
      else
         w_y = in_y;
   end

   // Counters restart on sof and saturate; the eof total includes this pixel.
   always_comb begin
      w_salt_base   = in_sof ? '0 : r_salt;
      w_pepper_base = in_sof ? '0 : r_pepper;
      w_salt_new    = (w_salt_hit && (w_salt_base != '1)) ? w_salt_base + C_ONE : w_salt_base;
      w_pepper_new  = (w_pepper_hit && (w_pepper_base != '1)) ? w_pepper_base + C_ONE : w_pepper_base;
      w_sum         = {1'b0, w_salt_new} + {1'b0, w_pepper_new};
      w_sum_sat     = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_lfsr       <= C_SEED;
         r_out_valid  <= 1'b0;
         r_out_y      <= '0;
         r_out_sof    <= 1'b0;
         r_out_eof    <= 1'b0;
         r_salt       <= '0;
         r_pepper     <= '0;
         r_frame_hits <= '0;
      end else if (w_accept) begin
         r_lfsr      <= w_l_next;
         r_out_valid <= 1'b1;
         r_out_y     <= w_y;
         r_out_sof   <= in_sof;
         r_out_eof   <= in_eof;
         r_salt      <= w_salt_new;
         r_pepper    <= w_pepper_new;
         if (in_eof)
            r_frame_hits <= w_sum_sat;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid  = r_out_valid;
   assign out_y      = r_out_y;
   assign out_sof    = r_out_sof;
   assign out_eof    = r_out_eof;
   assign salt_cnt   = r_salt;
   assign pepper_cnt = r_pepper;
   assign frame_hits = r_frame_hits;

endmodule

// File: tb/tb_sp_noise_injector.sv
// Scoreboard bench for sp_noise_injector: an independent LFSR/counter model
// queues expected pixels on input accept; a negedge monitor pops and compares.
module tb_sp_noise_injector;

   localparam int unsigned CNT_W = 20;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             noise_en;
   logic [8:0]       density;
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       in_y;
   logic             in_sof;
   logic             in_eof;
   logic             out_valid;
   logic             out_ready;
   logic [7:0]       out_y;
   logic             out_sof;
   logic             out_eof;
   logic [CNT_W-1:0] salt_cnt;
   logic [CNT_W-1:0] pepper_cnt;
   logic [CNT_W-1:0] frame_hits;

   always #5 clk = ~clk;

   sp_noise_injector #(
      .SALT_VAL   (8'd255),
      .PEPPER_VAL (8'd0),
      .LFSR_SEED  (16'hACE1),
      .CNT_W      (CNT_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .noise_en   (noise_en),
      .density    (density),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_y       (in_y),
      .in_sof     (in_sof),
      .in_eof     (in_eof),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_y      (out_y),
      .out_sof    (out_sof),
      .out_eof    (out_eof),
      .salt_cnt   (salt_cnt),
      .pepper_cnt (pepper_cnt),
      .frame_hits (frame_hits)
   );

   typedef struct packed {
      logic       sof;
      logic       eof;
      logic [7:0] y;
   } pix_t;

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Reference model state
   logic [15:0]      m_lfsr = 16'hACE1;
   logic [CNT_W-1:0] m_salt = '0;
   logic [CNT_W-1:0] m_pep  = '0;
   logic [CNT_W-1:0] m_fh   = '0;
   pix_t             q_exp[$];
   logic [7:0]       q_got[$];
   logic [7:0]       last_y = '0;
   pix_t             e_pop;
   pix_t             held;
   logic             stall_prev = 1'b0;
   int               rdy_mode = 0;

   task automatic model_push();
      logic [15:0]    l;
      logic [8:0]     d;
      logic           hit;
      logic [CNT_W:0] s;
      pix_t           e;
      l   = in_sof ? 16'hACE1 : m_lfsr;
      d   = (density > 9'd256) ? 9'd256 : density;
      hit = noise_en && ({1'b0, l[7:0]} < d);
      e.sof = in_sof;
      e.eof = in_eof;
      e.y   = hit ? (l[8] ? 8'd255 : 8'd0) : in_y;
      if (in_sof) begin
         m_salt = '0;
         m_pep  = '0;
      end
      if (hit && l[8] && (m_salt != '1))
         m_salt = m_salt + 1'b1;
      if (hit && !l[8] && (m_pep != '1))
         m_pep = m_pep + 1'b1;
      if (in_eof) begin
         s    = {1'b0, m_salt} + {1'b0, m_pep};
         m_fh = s[CNT_W] ? '1 : s[CNT_W-1:0];
      end
      m_lfsr = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
      q_exp.push_back(e);
   endtask

   // Monitor: output pop precedes input push because the output register
   // holds the older pixel.
   always @(negedge clk) begin
      if (!rst_n) begin
         q_exp.delete();
         m_lfsr     = 16'hACE1;
         m_salt     = '0;
         m_pep      = '0;
         m_fh       = '0;
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_data", {22'd0, out_sof, out_eof, out_y}, {22'd0, held});
         end
         if (out_valid && out_ready) begin
            if (q_exp.size() == 0) begin
               chk("spurious_out", 32'd1, 32'd0);
            end else begin
               e_pop = q_exp.pop_front();
               chk("pixel", {22'd0, out_sof, out_eof, out_y}, {22'd0, e_pop});
               q_got.push_back(out_y);
               last_y = out_y;
            end
         end
         stall_prev = out_valid && !out_ready;
         held       = {out_sof, out_eof, out_y};
         if (in_valid && in_ready)
            model_push();
      end
   end

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'($urandom_range(0, 1));
         default: out_ready = 1'b0;
      endcase
   end

   task automatic send(input logic [7:0] y, input logic sof, input logic eof);
      int unsigned n;
      logic        acc;
      n        = 0;
      acc      = 1'b0;
      in_valid = 1'b1;
      in_y     = y;
      in_sof   = sof;
      in_eof   = eof;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!acc)
         chk("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_eof   = 1'b0;
   endtask

   task automatic drain();
      int unsigned n;
      n = 0;
      while ((q_exp.size() != 0 || out_valid) && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 500)
         chk("drain_timeout", 32'd0, 32'd1);
   endtask

   task automatic send_frame(input int unsigned len, input logic rnd_ctl);
      for (int unsigned i = 0; i < len; i++) begin
         if (rnd_ctl) begin
            density  = 9'($urandom_range(0, 300));
            noise_en = 1'($urandom_range(0, 3) != 0);
         end
         send(8'($urandom), i == 0, i == len - 1);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   logic [7:0] frame_px[40];
   logic [7:0] got1[$];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n     = 1'b0;
      noise_en  = 1'b0;
      density   = '0;
      in_valid  = 1'b0;
      in_y      = '0;
      in_sof    = 1'b0;
      in_eof    = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_y", {24'd0, out_y}, 32'd0);
      chk("rst_out_sof", {31'd0, out_sof}, 32'd0);
      chk("rst_out_eof", {31'd0, out_eof}, 32'd0);
      chk("rst_salt", 32'(salt_cnt), 32'd0);
      chk("rst_pepper", 32'(pepper_cnt), 32'd0);
      chk("rst_frame_hits", 32'(frame_hits), 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;

      // Known first pixel: L=ACE1, r=225, L[8]=0
      noise_en = 1'b1;
      density  = 9'd226;
      send(8'd100, 1'b1, 1'b0);
      drain();
      chk("d226_y", {24'd0, last_y}, 32'd0);
      chk("d226_pepper", 32'(pepper_cnt), 32'd1);
      chk("d226_salt", 32'(salt_cnt), 32'd0);

      density = 9'd225;
      send(8'd100, 1'b1, 1'b1);
      drain();
      chk("d225_y", {24'd0, last_y}, 32'd100);
      chk("d225_salt", 32'(salt_cnt), 32'd0);
      chk("d225_pepper", 32'(pepper_cnt), 32'd0);
      chk("d225_frame_hits", 32'(frame_hits), 32'd0);

      density = 9'd0;
      send_frame(64, 1'b0);
      drain();
      chk("d0_frame_hits", 32'(frame_hits), 32'd0);

      noise_en = 1'b0;
      density  = 9'd256;
      send_frame(64, 1'b0);
      drain();
      chk("bypass_frame_hits", 32'(frame_hits), 32'd0);

      noise_en = 1'b1;
      density  = 9'd256;
      q_got.delete();
      send_frame(16, 1'b0);
      drain();
      foreach (q_got[i])
         chk("d256_salt_or_pepper", {31'd0, (q_got[i] == 8'd255) || (q_got[i] == 8'd0)}, 32'd1);
      chk("d256_cnt_sum", 32'(salt_cnt) + 32'(pepper_cnt), 32'd16);
      chk("d256_frame_hits", 32'(frame_hits), 32'd16);

      density = 9'd300;
      send_frame(16, 1'b0);
      drain();
      chk("d300_frame_hits", 32'(frame_hits), 32'd16);

      send_frame(48, 1'b1);
      drain();
      chk("mixed_frame_hits", 32'(frame_hits), 32'(m_fh));
      chk("mixed_salt", 32'(salt_cnt), 32'(m_salt));
      chk("mixed_pepper", 32'(pepper_cnt), 32'(m_pep));

      // Two identical frames under random backpressure
      noise_en = 1'b1;
      density  = 9'd128;
      foreach (frame_px[i])
         frame_px[i] = 8'($urandom);
      rdy_mode = 1;
      q_got.delete();
      foreach (frame_px[i])
         send(frame_px[i], i == 0, i == 39);
      drain();
      got1 = q_got;
      q_got.delete();
      foreach (frame_px[i])
         send(frame_px[i], i == 0, i == 39);
      drain();
      chk("bp_count1", got1.size(), 32'd40);
      chk("bp_count2", q_got.size(), 32'd40);
      if (got1.size() == 40 && q_got.size() == 40)
         foreach (got1[i])
            chk("bp_repeat", {24'd0, q_got[i]}, {24'd0, got1[i]});
      chk("bp_frame_hits", 32'(frame_hits), 32'(m_fh));

      // Reset while a pixel is held under backpressure
      rdy_mode = 2;
      @(posedge clk);
      #1;
      send(8'd7, 1'b1, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("held_valid", {31'd0, out_valid}, 32'd1);
      do_reset();
      @(negedge clk);
      chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      rdy_mode = 0;
      density  = 9'd226;
      send(8'd100, 1'b1, 1'b0);
      drain();
      chk("midrst_y", {24'd0, last_y}, 32'd0);
      chk("midrst_pepper", 32'(pepper_cnt), 32'd1);
      chk("midrst_salt", 32'(salt_cnt), 32'd0);
      chk("sb_empty", q_exp.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
